stage_exma_pipe: RTL and testbench

- Parametrised, elastic EX→MA pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Carries ALU result, PC, immediate and destination register from the execute stage to the memory-access stage.
- Adds three things a plain enable register lacks: backpressure without a combinational ready path, flush (bubble insertion), and an x0-safe destination for hazard logic.

---
 rtl/stage_exma_pipe.sv | 103 ++++++++++
 tb/tb_stage_exma_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_exma_pipe.sv
// EX->MA elastic pipeline register: valid/ready handshake, 2-entry skid buffer, flush, x0-safe rd_out.
// Optional STAGE_EXMA_PERF_EN adds stall_cnt / bubble_cnt performance counters.
module stage_exma_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned IMM_W = 12,
  parameter int unsigned RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  busc_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [IMM_W-1:0] imm_in,
  input  logic [RD_W-1:0]  rd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  busc_out,
  output logic [XLEN-1:0]  pc_out,
  output logic [IMM_W-1:0] imm_out,
  output logic [RD_W-1:0]  rd_out
`ifdef STAGE_EXMA_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  localparam int unsigned PW = 2 * XLEN + IMM_W + RD_W;

  logic          v_m, v_s, vm_d, vs_d;
  logic [PW-1:0] m_q, s_q, m_d, s_d;
  logic [PW-1:0] in_bus;
  logic [RD_W-1:0] rd_m;
  logic          acc, drn;

  assign in_bus = {busc_in, pc_in, imm_in, rd_in};

  // in_ready depends only on the skid valid flop, never on out_ready.
  assign in_ready  = ~v_s;
  assign out_valid = v_m;
  assign acc       = in_valid & ~v_s;
  assign drn       = v_m & out_ready;

  always_comb begin
    vm_d = v_m;
    vs_d = v_s;
    m_d  = m_q;
    s_d  = s_q;
    if (flush) begin
      vm_d = 1'b0;
      vs_d = 1'b0;
    end else if (!v_m) begin
      if (acc) begin
        m_d  = in_bus;
        vm_d = 1'b1;
      end
    end else if (drn) begin
      if (v_s) begin
        m_d  = s_q;
        vs_d = 1'b0;
      end else if (acc) begin
        m_d = in_bus;
      end else begin
        vm_d = 1'b0;
      end
    end else if (acc) begin
      s_d  = in_bus;
      vs_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_m <= 1'b0;
      v_s <= 1'b0;
      m_q <= '0;
      s_q <= '0;
    end else begin
      v_m <= vm_d;
      v_s <= vs_d;
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  assign {busc_out, pc_out, imm_out, rd_m} = m_q;
  assign rd_out = v_m ? rd_m : '0;

`ifdef STAGE_EXMA_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (v_m && !out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (!v_m)              bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_exma_pipe.sv
// Self-checking bench for stage_exma_pipe: queue-based FIFO model, directed scenarios, random traffic.
`timescale 1ns/1ps
module tb_stage_exma_pipe;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned IMM_W = 12;
  localparam int unsigned RD_W  = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [XLEN-1:0]  busc_in = '0;
  logic [XLEN-1:0]  pc_in = '0;
  logic [IMM_W-1:0] imm_in = '0;
  logic [RD_W-1:0]  rd_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  busc_out;
  logic [XLEN-1:0]  pc_out;
  logic [IMM_W-1:0] imm_out;
  logic [RD_W-1:0]  rd_out;
`ifdef STAGE_EXMA_PERF_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      bubble_cnt;
`endif

  stage_exma_pipe #(.XLEN(XLEN), .IMM_W(IMM_W), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .busc_in(busc_in), .pc_in(pc_in), .imm_in(imm_in), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .busc_out(busc_out), .pc_out(pc_out), .imm_out(imm_out), .rd_out(rd_out)
`ifdef STAGE_EXMA_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0]  busc;
    logic [XLEN-1:0]  pc;
    logic [IMM_W-1:0] imm;
    logic [RD_W-1:0]  rd;
  } bundle_t;

  // Model: the stage is a 2-deep FIFO; outputs show the head, or the last head once emptied.
  bundle_t     q[$];
  bundle_t     shown;
  bit          dc;
  bit          started;
  logic [31:0] m_stall, m_bubble;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit acc, drn;
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    if (rst) begin
      q.delete();
      shown = '0;
      dc = 1'b0;
      started = 1'b1;
      m_stall = '0;
      m_bubble = '0;
    end else begin
      if (q.size() > 0 && !out_ready) m_stall = m_stall + 32'd1;
      if (q.size() == 0) m_bubble = m_bubble + 32'd1;
      if (flush) begin
        q.delete();
        dc = 1'b1;
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back({busc_in, pc_in, imm_in, rd_in});
        if (q.size() > 0) begin
          shown = q[0];
          dc = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      cmp("out_valid", 64'(out_valid), 64'(q.size() > 0));
      cmp("in_ready", 64'(in_ready), 64'(q.size() < 2));
      cmp("rd_out", 64'(rd_out), (q.size() > 0) ? 64'(q[0].rd) : 64'd0);
      if (!(dc && q.size() == 0)) begin
        cmp("busc_out", 64'(busc_out), 64'(shown.busc));
        cmp("pc_out", 64'(pc_out), 64'(shown.pc));
        cmp("imm_out", 64'(imm_out), 64'(shown.imm));
      end
`ifdef STAGE_EXMA_PERF_EN
      cmp("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      cmp("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
    end
  end

  // One edge with the given inputs; returns 2ns after that edge.
  task automatic cyc(input bit r, input bit fl, input bit iv, input bit ordy,
                     input logic [31:0] b, input logic [RD_W-1:0] d);
    @(negedge clk);
    #1;
    rst = r;
    flush = fl;
    in_valid = iv;
    out_ready = ordy;
    busc_in = b;
    pc_in = b ^ 32'h8000_0040;
    imm_in = b[11:0] ^ 12'h5a5;
    rd_in = d;
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] A = 32'hAAAA_0000;
  localparam logic [31:0] B = 32'hBBBB_0000;
  localparam logic [31:0] C = 32'hCCCC_0000;

  initial begin
    // reset then idle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      cmp("idle_out_valid", 64'(out_valid), 64'd0);
      cmp("idle_in_ready", 64'(in_ready), 64'd1);
      cmp("idle_rd_out", 64'(rd_out), 64'd0);
      cmp("idle_busc_out", 64'(busc_out), 64'd0);
    end

    // streaming
    cyc(0, 0, 1, 1, 32'h11, 5'd1);
    cmp("s1_busc", 64'(busc_out), 64'h11);
    cmp("s1_rd", 64'(rd_out), 64'd1);
    cyc(0, 0, 1, 1, 32'h22, 5'd2);
    cmp("s2_busc", 64'(busc_out), 64'h22);
    cmp("s2_in_ready", 64'(in_ready), 64'd1);
    cyc(0, 0, 1, 1, 32'h33, 5'd3);
    cmp("s3_busc", 64'(busc_out), 64'h33);
    cmp("s3_rd", 64'(rd_out), 64'd3);
    cyc(0, 0, 0, 1, 0, 0);
    cmp("s_drain_valid", 64'(out_valid), 64'd0);
    cmp("s_drain_rd", 64'(rd_out), 64'd0);
    cmp("s_drain_busc_hold", 64'(busc_out), 64'h33);

    // backpressure
    cyc(0, 0, 1, 0, A, 5'd4);
    cmp("bp_A_valid", 64'(out_valid), 64'd1);
    cyc(0, 0, 1, 0, B, 5'd5);
    cmp("bp_in_ready_low", 64'(in_ready), 64'd0);
    cmp("bp_A_held", 64'(busc_out), 64'(A));
    cyc(0, 0, 0, 1, 0, 0);
    cmp("bp_B_next", 64'(busc_out), 64'(B));
    cmp("bp_in_ready_back", 64'(in_ready), 64'd1);
    cyc(0, 0, 0, 1, 0, 0);
    cmp("bp_empty", 64'(out_valid), 64'd0);

    // flush with full buffer and a simultaneous push
    cyc(0, 0, 1, 0, A, 5'd4);
    cyc(0, 0, 1, 0, B, 5'd5);
    cyc(0, 1, 1, 0, C, 5'd7);
    cmp("fl_valid", 64'(out_valid), 64'd0);
    cmp("fl_rd", 64'(rd_out), 64'd0);
    cmp("fl_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      cmp("fl_no_C", 64'(out_valid), 64'd0);
    end

    // reset mid-operation
    cyc(0, 0, 1, 0, A, 5'd4);
    cyc(1, 0, 0, 0, 0, 0);
    cmp("rm_valid", 64'(out_valid), 64'd0);
    cmp("rm_busc", 64'(busc_out), 64'd0);
    cyc(0, 0, 1, 1, 32'h1234, 5'd9);
    cmp("rm_D_busc", 64'(busc_out), 64'h1234);
    cmp("rm_D_rd", 64'(rd_out), 64'd9);
    cyc(0, 0, 0, 1, 0, 0);
    cmp("rm_D_alone", 64'(out_valid), 64'd0);

`ifdef STAGE_EXMA_PERF_EN
    // one empty push cycle, 3 stalls, drain, one empty cycle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, A, 5'd4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cmp("perf_stall", 64'(stall_cnt), 64'd3);
    cmp("perf_bubble", 64'(bubble_cnt), 64'd2);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1),
          $urandom, 5'($urandom));
    end
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
